// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed scan controller for an N-digit common-anode seven-segment
//   display. One shared hex decoder serves all digits; each digit owns a slot
//   of DIV clocks, and the first GAP clocks of every slot are dark so the
//   previous digit's pattern cannot ghost onto the next anode.
//   Display values are double-buffered (pending -> shadow). The shadow copy
//   only changes at a frame boundary, or while the scan is disabled, so a
//   frame never shows a mix of old and new digits.
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_en          scan enable; 0 = dark display, counters held at 0
//   i_load        capture i_value into the pending buffer on this edge
//   i_value       4*NUM_DIGITS bits of hex digits, digit 0 rightmost
//   i_blank       per-digit force-off mask, applied live
//   i_lz_blank    1 = blank leading zero digits (digit 0 never blanked)
//   o_seg         active-low segments, bit0 = a ... bit6 = g
//   o_an          active-low digit enables
//   o_frame_done  1-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int GAP        = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_load,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_blank,
    input  logic                      i_lz_blank,
    output logic [6:0]                o_seg,
    output logic [NUM_DIGITS-1:0]     o_an,
    output logic                      o_frame_done
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF  = 7'h7F;

    // Shared hex decoder, active-low segments.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CW-1:0]                r_cnt;
    logic [IW-1:0]                r_idx;
    logic [NUM_DIGITS-1:0][3:0]   r_pending;
    logic [NUM_DIGITS-1:0][3:0]   r_shadow;
    logic                         r_pend_v;

    // -----------------------------------------------------------------------
    // Scan timing
    // -----------------------------------------------------------------------
    logic w_cnt_last;
    logic w_idx_last;
    logic w_frame_end;
    logic w_commit;
    logic w_in_gap;

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_idx_last  = (r_idx == IDX_LAST);
    assign w_frame_end = i_en & w_cnt_last & w_idx_last;
    // While disabled the display is dark, so committing immediately is safe.
    assign w_commit    = r_pend_v & (w_frame_end | ~i_en);
    assign w_in_gap    = (r_cnt < CNT_GAP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Double buffer. A load on the commit edge still lands in pending: the
    // commit moves the older pending value, the new one waits a frame.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
            r_shadow  <= '0;
            r_pend_v  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_shadow <= r_pending;
            end
            if (i_load) begin
                r_pending <= i_value;
                r_pend_v  <= 1'b1;
            end else if (w_commit) begin
                r_pend_v  <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Blanking: w_hi_zero[i] = digits i..NUM_DIGITS-1 of shadow are all zero.
    // -----------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_hi_zero;
    logic [NUM_DIGITS-1:0] w_blank_mask;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        if (gi == NUM_DIGITS - 1) begin : g_top
            assign w_hi_zero[gi] = (r_shadow[gi] == 4'h0);
        end else begin : g_low
            assign w_hi_zero[gi] = (r_shadow[gi] == 4'h0) & w_hi_zero[gi+1];
        end

        if (gi == 0) begin : g_d0
            assign w_blank_mask[gi] = i_blank[gi];
        end else begin : g_dn
            assign w_blank_mask[gi] = i_blank[gi] | (i_lz_blank & w_hi_zero[gi]);
        end
    end

    // -----------------------------------------------------------------------
    // Output registers, driven from the pre-edge cnt/idx/shadow.
    // -----------------------------------------------------------------------
    logic [3:0]            w_cur_digit;
    logic                  w_cur_blank;
    logic [NUM_DIGITS-1:0] w_onecold;

    assign w_cur_digit = r_shadow[r_idx];
    assign w_cur_blank = w_blank_mask[r_idx];
    assign w_onecold   = ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_an         <= '1;
            o_seg        <= SEG_OFF;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= w_frame_end;
            if (!i_en || w_in_gap) begin
                o_an  <= '1;
                o_seg <= SEG_OFF;
            end else begin
                // A blanked digit keeps its anode on with all segments off.
                o_an  <= w_onecold;
                o_seg <= w_cur_blank ? SEG_OFF : f_decode(w_cur_digit);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Directed bench for seven_seg_scanner (NUM_DIGITS=4, DIV=8, GAP=2).
//   A cycle model derives every output from elapsed enabled time and the
//   buffered values; a compare process checks it each falling edge, and the
//   directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int GAP = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic        lz    = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        fd;

    seven_seg_scanner #(.NUM_DIGITS(N), .DIV(DIV), .GAP(GAP)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_load       (load),
        .i_value      (value),
        .i_blank      (blank),
        .i_lz_blank   (lz),
        .o_seg        (seg),
        .o_an         (an),
        .o_frame_done (fd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Model: position in the scan comes from elapsed enabled cycles.
    // ---------------------------------------------------------------------
    logic [6:0]  SEG_TAB [16];
    int          m_t;
    int          m_pos;
    int          m_dig;
    logic [15:0] m_sh;
    logic [15:0] m_pe;
    logic        m_pv;
    logic [3:0]  m_d;
    logic        m_blk;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;

    initial begin
        SEG_TAB = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_t = 0; m_sh = 0; m_pe = 0; m_pv = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_fd = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_t = 0; m_sh = 0; m_pe = 0; m_pv = 0;
                e_an = 4'hF; e_seg = 7'h7F; e_fd = 0;
            end else begin
                if (!en) begin
                    e_an = 4'hF; e_seg = 7'h7F; e_fd = 0;
                    if (m_pv) begin m_sh = m_pe; m_pv = 0; end
                    m_t = 0;
                end else begin
                    m_pos = m_t % DIV;
                    m_dig = (m_t / DIV) % N;
                    if (m_pos < GAP) begin
                        e_an = 4'hF; e_seg = 7'h7F;
                    end else begin
                        e_an  = ~(4'b0001 << m_dig);
                        m_d   = m_sh[4*m_dig +: 4];
                        m_blk = blank[m_dig] || (lz && m_dig > 0 && (m_sh >> (4*m_dig)) == 16'h0);
                        e_seg = m_blk ? 7'h7F : SEG_TAB[m_d];
                    end
                    e_fd = ((m_t % (DIV*N)) == DIV*N - 1);
                    if (e_fd && m_pv) begin m_sh = m_pe; m_pv = 0; end
                    m_t++;
                end
                if (load) begin m_pe = value; m_pv = 1; end
            end
        end
    end

    // Compare process: every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("an",  16'(an),  16'(e_an));
            check("seg", 16'(seg), 16'(e_seg));
            check("frame_done", 16'(fd), 16'(e_fd));
        end
    end

    // ---------------------------------------------------------------------
    // Directed helpers
    // ---------------------------------------------------------------------
    task automatic wait_an(input logic [3:0] tgt, input logic [6:0] exp_seg, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (an !== tgt && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (an !== tgt) check({name, "_timeout"}, 16'(an), 16'(tgt));
        else            check(name, 16'(seg), 16'(exp_seg));
    endtask

    task automatic wait_fd(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (fd !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (fd !== 1'b1) check({name, "_timeout"}, 16'(fd), 16'h1);
    endtask

    // Load a value while disabled, then re-enable.
    task automatic load_dark(input logic [15:0] v);
        @(negedge clk);
        en = 0; load = 1; value = v;
        @(negedge clk);
        load = 0;
        @(negedge clk);
        en = 1;
    endtask

    initial begin
        int fcnt;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_an",  16'(an),  16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_fd",  16'(fd),  16'h0);

        // Idle scan: 0000 everywhere, frame_done once per 32 cycles.
        rst_n = 1; en = 1;
        fcnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (fd) fcnt++;
        end
        check("fd_count", 16'(fcnt), 16'd2);
        wait_an(4'hE, 7'h40, "idle_d0");
        wait_an(4'h7, 7'h40, "idle_d3");

        // Load while disabled.
        load_dark(16'h12AF);
        wait_an(4'hE, 7'h0E, "12AF_d0");
        wait_an(4'hD, 7'h08, "12AF_d1");
        wait_an(4'hB, 7'h24, "12AF_d2");
        wait_an(4'h7, 7'h79, "12AF_d3");

        // Mid-frame load: current frame unaffected.
        load_dark(16'h1234);
        wait_an(4'hD, 7'h30, "1234_d1");
        load = 1; value = 16'h8888;
        @(negedge clk);
        load = 0;
        wait_an(4'h7, 7'h79, "1234_d3_hold");
        wait_fd("fd_8888");
        wait_an(4'hE, 7'h00, "8888_d0");
        wait_an(4'h7, 7'h00, "8888_d3");

        // Load exactly on the boundary edge with an older value pending.
        wait_fd("fd_align");
        load = 1; value = 16'h9999;
        @(negedge clk);
        load = 0;
        repeat (30) @(negedge clk);
        load = 1; value = 16'h5555;
        @(negedge clk);
        load = 0;
        check("bnd_edge_fd", 16'(fd), 16'h1);
        wait_an(4'hE, 7'h10, "9999_d0");
        wait_an(4'h7, 7'h10, "9999_d3");
        wait_fd("fd_5555");
        wait_an(4'hE, 7'h12, "5555_d0");

        // Leading-zero blanking.
        lz = 1;
        load_dark(16'h0070);
        wait_an(4'hE, 7'h40, "lz70_d0");
        wait_an(4'hD, 7'h78, "lz70_d1");
        wait_an(4'hB, 7'h7F, "lz70_d2");
        wait_an(4'h7, 7'h7F, "lz70_d3");
        load_dark(16'h0000);
        wait_an(4'hE, 7'h40, "lz0_d0");
        wait_an(4'hD, 7'h7F, "lz0_d1");
        wait_an(4'h7, 7'h7F, "lz0_d3");
        lz = 0;

        // Live per-digit blank mask.
        load_dark(16'h1234);
        blank = 4'b0100;
        wait_an(4'hB, 7'h7F, "blank_d2");
        wait_an(4'h7, 7'h79, "blank_d3");
        blank = 4'b0000;

        // Asynchronous reset during slot idx 2.
        wait_an(4'hB, 7'h24, "pre_rst_d2");
        #2 rst_n = 0;
        #1;
        check("arst_an",  16'(an),  16'hF);
        check("arst_seg", 16'(seg), 16'h7F);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_an(4'hE, 7'h40, "post_rst_d0");
        wait_an(4'hD, 7'h40, "post_rst_d1");
        wait_an(4'hB, 7'h40, "post_rst_d2");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
